// File: rtl/baud_pkg.sv
// Shared types and constants for the UART baud-rate tick generator.
package baud_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_DIV = 326;
    localparam int OVERSAMPLE  = 16;
    localparam int MIN_DIV     = 2;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator: each period boundary adds the fraction and
// stretches the following period by one clock when the sum carries out.
module baud_frac_acc #(
    parameter int FRAC_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_extend
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              extend_q, extend_d;
    logic [FRAC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, i_frac};

    always_comb begin
        acc_d    = acc_q;
        extend_d = extend_q;
        if (i_clear) begin
            acc_d    = '0;
            extend_d = 1'b0;
        end else if (i_step) begin
            acc_d    = sum[FRAC_W-1:0];
            extend_d = sum[FRAC_W];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q    <= '0;
            extend_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            extend_q <= extend_d;
        end
    end

    assign o_extend = extend_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable oversampling baud tick generator with shadowed divisor reload.
// Define BAUD_FRAC_EN to compile in the fractional divisor accumulator.
module baud_tick_gen #(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OVERSAMPLE  = baud_pkg::OVERSAMPLE,
    parameter int DEFAULT_DIV = baud_pkg::DEFAULT_DIV
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_load,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_sync,
    output logic              o_tick,
    output logic              o_bit_tick,
    output logic              o_div_err
);

    import baud_pkg::*;

    localparam int OS_W = $clog2(OVERSAMPLE);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  activeInt_q, activeInt_d;
    logic [DIV_W-1:0]  shadowInt_q, shadowInt_d;
    logic              pending_q, pending_d;
    logic [DIV_W-1:0]  count_q, count_d;
    logic [OS_W-1:0]   osCount_q, osCount_d;
    logic              tick_q, tick_d;
    logic              bitTick_q, bitTick_d;
    logic              divErr, running, boundary, clearPhase, apply, extend;
    logic [DIV_W:0]    periodLen;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] activeFrac_q, activeFrac_d;
    logic [FRAC_W-1:0] shadowFrac_q, shadowFrac_d;

    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_fracAcc (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (clearPhase),
        .i_step   (boundary),
        .i_frac   (activeFrac_q),
        .o_extend (extend)
    );
`else
    logic [FRAC_W-1:0] unusedFrac;
    assign unusedFrac = i_div_frac;
    assign extend     = 1'b0;
`endif

    assign divErr     = activeInt_q < DIV_W'(MIN_DIV);
    assign running    = (state_q == RUN) && i_enable && !divErr;
    assign clearPhase = !running || i_sync;
    // Extra bit keeps a max-width divisor plus extend from wrapping the compare.
    assign periodLen  = {1'b0, activeInt_q} + (DIV_W+1)'(extend);
    assign boundary   = running && !i_sync &&
                        ({1'b0, count_q} == periodLen - (DIV_W+1)'(1));
    assign apply      = pending_q && ((state_q == IDLE) || boundary);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_enable && !divErr) state_d = RUN;
            RUN:     if (!i_enable || divErr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        activeInt_d = activeInt_q;
        shadowInt_d = shadowInt_q;
        pending_d   = pending_q;
`ifdef BAUD_FRAC_EN
        activeFrac_d = activeFrac_q;
        shadowFrac_d = shadowFrac_q;
`endif
        if (apply) begin
            activeInt_d = shadowInt_q;
`ifdef BAUD_FRAC_EN
            activeFrac_d = shadowFrac_q;
`endif
            pending_d   = 1'b0;
        end
        if (i_load) begin
            shadowInt_d = i_div_int;
`ifdef BAUD_FRAC_EN
            shadowFrac_d = i_div_frac;
`endif
            pending_d   = 1'b1;
        end
    end

    always_comb begin
        tick_d    = boundary;
        bitTick_d = boundary && (osCount_q == OS_W'(OVERSAMPLE - 1));
        count_d   = count_q + DIV_W'(1);
        osCount_d = osCount_q;
        if (clearPhase) begin
            count_d   = '0;
            osCount_d = '0;
        end else if (boundary) begin
            count_d   = '0;
            osCount_d = osCount_q + OS_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            activeInt_q <= DIV_W'(DEFAULT_DIV);
            shadowInt_q <= DIV_W'(DEFAULT_DIV);
            pending_q   <= 1'b0;
            count_q     <= '0;
            osCount_q   <= '0;
            tick_q      <= 1'b0;
            bitTick_q   <= 1'b0;
`ifdef BAUD_FRAC_EN
            activeFrac_q <= '0;
            shadowFrac_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            activeInt_q <= activeInt_d;
            shadowInt_q <= shadowInt_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            osCount_q   <= osCount_d;
            tick_q      <= tick_d;
            bitTick_q   <= bitTick_d;
`ifdef BAUD_FRAC_EN
            activeFrac_q <= activeFrac_d;
            shadowFrac_q <= shadowFrac_d;
`endif
        end
    end

    assign o_tick     = tick_q;
    assign o_bit_tick = bitTick_q;
    assign o_div_err  = divErr;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: expected tick cycles are queued as stimulus
// is applied and checked by a monitor as the DUT produces ticks.
module tb_baud_tick_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic        sync;
    logic [15:0] divInt;
    logic [3:0]  divFrac;
    logic        tick;
    logic        bitTick;
    logic        divErr;

    int     cycle      = 0;
    int     compared   = 0;
    int     mismatched = 0;
    longint expTickQ[$];
    longint expBitQ[$];

    baud_tick_gen dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_enable   (enable),
        .i_load     (load),
        .i_div_int  (divInt),
        .i_div_frac (divFrac),
        .i_sync     (sync),
        .o_tick     (tick),
        .o_bit_tick (bitTick),
        .o_div_err  (divErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] dInt,
                                 input logic [3:0] dFrac, input logic sy);
        enable  = en;
        load    = ld;
        divInt  = dInt;
        divFrac = dFrac;
        sync    = sy;
    endtask

    task automatic pulseLoad(input logic [15:0] dInt, input logic [3:0] dFrac);
        applyStimulus(enable, 1'b1, dInt, dFrac, 1'b0);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic waitUntil(input longint target);
        while (cycle < target) @(negedge clk);
    endtask

    task automatic finishPhase(input string tag);
        @(negedge clk);
        checkOutput({tag, " ticks outstanding"}, expTickQ.size(), 0);
        checkOutput({tag, " bit ticks outstanding"}, expBitQ.size(), 0);
    endtask

    // Monitor: every tick must match the oldest queued expectation.
    always @(negedge clk) begin
        if (tick) begin
            if (expTickQ.size() == 0) checkOutput("unexpected o_tick at cycle", cycle, -1);
            else                      checkOutput("o_tick cycle", cycle, expTickQ.pop_front());
        end
        if (bitTick) begin
            if (expBitQ.size() == 0) checkOutput("unexpected o_bit_tick at cycle", cycle, -1);
            else                     checkOutput("o_bit_tick cycle", cycle, expBitQ.pop_front());
        end
    end

    initial begin
        longint n;
        longint t;
        int     iv[5];

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset o_tick", tick, 0);
        checkOutput("reset o_bit_tick", bitTick, 0);
        checkOutput("reset o_div_err", divErr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle o_tick", tick, 0);

        // Default divisor: ticks every 326 from RUN entry, bit tick on the 16th.
        n = cycle;
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) expTickQ.push_back(n + 1 + 326 * k);
        expBitQ.push_back(n + 1 + 326 * 16);
        waitUntil(n + 1 + 326 * 16);
        finishPhase("default divisor");
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Sync at counter 200 restarts the period and the oversample phase.
        n = cycle;
        enable = 1'b1;
        waitUntil(n + 201);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        for (int k = 1; k <= 16; k++) expTickQ.push_back(n + 202 + 326 * k);
        expBitQ.push_back(n + 202 + 326 * 16);
        waitUntil(n + 202 + 326 * 16);
        finishPhase("sync");
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Reload mid-period takes effect only at the next period boundary.
        pulseLoad(16'd100, 4'd0);
        repeat (3) @(negedge clk);
        n = cycle;
        enable = 1'b1;
        expTickQ.push_back(n + 101);
        expTickQ.push_back(n + 151);
        expTickQ.push_back(n + 201);
        expTickQ.push_back(n + 251);
        waitUntil(n + 41);
        pulseLoad(16'd50, 4'd0);
        waitUntil(n + 251);
        finishPhase("mid-period reload");
        checkOutput("reload o_div_err", divErr, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Fractional divisor 10 + 8/16.
`ifdef BAUD_FRAC_EN
        iv = '{10, 10, 11, 10, 11};
`else
        iv = '{10, 10, 10, 10, 10};
`endif
        pulseLoad(16'd10, 4'd8);
        repeat (3) @(negedge clk);
        n = cycle;
        enable = 1'b1;
        t = n + 1;
        for (int k = 0; k < 5; k++) begin
            t = t + iv[k];
            expTickQ.push_back(t);
        end
        waitUntil(t);
        finishPhase("fractional divisor");
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Illegal divisor suppresses ticks; a legal reload resumes them.
        pulseLoad(16'd1, 4'd0);
        @(negedge clk);
        checkOutput("div=1 o_div_err", divErr, 1);
        enable = 1'b1;
        waitUntil(cycle + 1000);
        finishPhase("illegal divisor");
        checkOutput("div=1 held o_div_err", divErr, 1);
        n = cycle;
        for (int k = 1; k <= 8; k++) expTickQ.push_back(n + 3 + 4 * k);
        pulseLoad(16'd4, 4'd0);
        @(negedge clk);
        checkOutput("div=4 o_div_err", divErr, 0);
        waitUntil(n + 35);

        // Async reset while o_tick is high.
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        checkOutput("async reset o_tick", tick, 0);
        checkOutput("async reset o_bit_tick", bitTick, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("post-reset o_div_err", divErr, 0);
        finishPhase("divisor 4");
        waitUntil(cycle + 50);
        n = cycle;
        enable = 1'b1;
        expTickQ.push_back(n + 1 + 326);
        expTickQ.push_back(n + 1 + 652);
        waitUntil(n + 1 + 652);
        finishPhase("post-reset default divisor");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
